queue_write_module: RTL and testbench

//  Producer-facing write end of a KPN channel. Accepts tokens pushed by an upstream process on a wr strobe.

---
 rtl/queue_write_module_pkg.sv | 13 +
 rtl/queue_write_module_ptr_ctrl.sv | 60 ++++++
 rtl/queue_write_module.sv | 69 ++++++
 tb/tb_queue_write_module.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/queue_write_module_pkg.sv
// Shared defaults for KPN channel queues: token width, log2 depth and the reset token value.
package queue_write_module_pkg;

    localparam int BITS_NUMBER_DEF   = 16;
    localparam int FIFO_ELEMENTS_DEF = 5;

    localparam logic [BITS_NUMBER_DEF-1:0] TOKEN_ZERO = '0;

    function automatic int depth_of(input int fifo_elements);
        return 1 << fifo_elements;
    endfunction

endpackage

// File: rtl/queue_write_module_ptr_ctrl.sv
// Pointer, level and flag bookkeeping for the channel FIFO; enables are combinational, state updates next edge.
// A write is accepted when full only if a read frees a slot in the same cycle; reads never bypass writes.
module queue_ptr_ctrl
    import queue_write_module_pkg::*;
#(
    parameter int FIFO_ELEMENTS = FIFO_ELEMENTS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [FIFO_ELEMENTS-1:0] w_ptr,
    output logic [FIFO_ELEMENTS-1:0] r_ptr,
    output logic [FIFO_ELEMENTS:0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam logic [FIFO_ELEMENTS:0]   LVL_ONE = (FIFO_ELEMENTS+1)'(1);
    localparam logic [FIFO_ELEMENTS:0]   LVL_MAX = (FIFO_ELEMENTS+1)'(depth_of(FIFO_ELEMENTS));
    localparam logic [FIFO_ELEMENTS-1:0] PTR_ONE = FIFO_ELEMENTS'(1);

    logic [FIFO_ELEMENTS:0] level_nxt;

    // Reads are gated by the registered empty flag, so a same-cycle write is never visible.
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd);

    always_comb begin
        level_nxt = level;
        if (wr_en && !rd_en) begin
            level_nxt = level + LVL_ONE;
        end else if (rd_en && !wr_en) begin
            level_nxt = level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_en) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_en) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_MAX);
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/queue_write_module.sv
// Write end of a KPN channel: buffers producer tokens, registered read data one cycle after rd.
// Producers block on full; a write rejected while full (no read) is dropped and latches overflow.
module queue_write_module
    import queue_write_module_pkg::*;
#(
    parameter int BITS_NUMBER   = BITS_NUMBER_DEF,
    parameter int FIFO_ELEMENTS = FIFO_ELEMENTS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [BITS_NUMBER-1:0]   input_1,
    input  logic                     rd,
    output logic [BITS_NUMBER-1:0]   output_1,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [FIFO_ELEMENTS:0]   level,
    output logic                     overflow
);

    localparam int DEPTH = depth_of(FIFO_ELEMENTS);

    logic [BITS_NUMBER-1:0]   array_reg [0:DEPTH-1];
    logic                     wr_en;
    logic                     rd_en;
    logic [FIFO_ELEMENTS-1:0] w_ptr;
    logic [FIFO_ELEMENTS-1:0] r_ptr;

    queue_ptr_ctrl #(
        .FIFO_ELEMENTS (FIFO_ELEMENTS)
    ) u_ptr_ctrl (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .rd    (rd),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .w_ptr (w_ptr),
        .r_ptr (r_ptr),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Storage is deliberately not reset; reset still blocks the write through the enable.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            array_reg[w_ptr] <= input_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            output_1 <= BITS_NUMBER'(TOKEN_ZERO);
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= rd_en;
            if (rd_en) begin
                output_1 <= array_reg[r_ptr];
            end
            if (wr && full && !rd) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_queue_write_module.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based channel model.
module tb_queue_write_module;

    localparam int BN    = 16;
    localparam int FE    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [BN-1:0] input_1;
    logic [BN-1:0] output_1;
    logic          valid;
    logic          full;
    logic          empty;
    logic [FE:0]   level;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BN-1:0] mq [$];
    logic [BN-1:0] m_out;
    logic          m_valid;
    logic          m_ovf;

    always #5 clk = ~clk;

    queue_write_module #(
        .BITS_NUMBER   (BN),
        .FIFO_ELEMENTS (FE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .input_1  (input_1),
        .rd       (rd),
        .output_1 (output_1),
        .valid    (valid),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from the falling edge, advance the model, compare just after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [BN-1:0] d, input logic rst);
        bit rd_ok;
        bit wr_ok;
        reset   = rst;
        wr      = w;
        rd      = r;
        input_1 = d;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_out   = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            rd_ok   = r && (mq.size() > 0);
            wr_ok   = w && ((mq.size() < DEPTH) || r);
            m_valid = rd_ok;
            if (rd_ok) m_out = mq.pop_front();
            if (wr_ok) mq.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1;
        end
        #1;
        check("output_1", 32'(output_1), 32'(m_out));
        check("valid",    32'(valid),    32'(m_valid));
        check("level",    32'(level),    32'(mq.size()));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; input_1 = '0;
        @(negedge clk);
        cycle(0, 0, '0, 1);
        cycle(1, 1, 16'h1234, 1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        // 1: five writes then five reads
        for (int i = 1; i <= 5; i++) cycle(1, 0, BN'(i), 0);
        check("t1_level", 32'(level), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 1, '0, 0);
            check("t1_data", 32'(output_1), 32'(i));
        end
        check("t1_empty", 32'(empty), 32'd1);

        // 2: fill, rejected write, drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, BN'(16'h0100 + i), 0);
        check("t2_full", 32'(full), 32'd1);
        cycle(1, 0, 16'hDEAD, 0);
        check("t2_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, '0, 0);
            check("t2_data", 32'(output_1), 32'(16'h0100 + i));
        end
        check("t2_empty", 32'(empty), 32'd1);

        // 3: simultaneous write and read while full
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, BN'(16'h0100 + i), 0);
        cycle(1, 1, 16'hBEEF, 0);
        check("t3_first", 32'(output_1), 32'h0100);
        check("t3_full", 32'(full), 32'd1);
        for (int i = 1; i <= DEPTH; i++) cycle(0, 1, '0, 0);
        check("t3_beef", 32'(output_1), 32'hBEEF);

        // 4: write and read while empty: write only
        cycle(1, 1, 16'h00AA, 0);
        check("t4_valid", 32'(valid), 32'd0);
        check("t4_level", 32'(level), 32'd1);
        cycle(0, 1, '0, 0);
        check("t4_data", 32'(output_1), 32'h00AA);

        // 5: prefill three, then stream through the pointer wrap
        for (int i = 0; i < 3; i++) cycle(1, 0, BN'(16'h2000 + i), 0);
        for (int i = 3; i < 43; i++) begin
            cycle(1, 1, BN'(16'h2000 + i), 0);
            check("t5_data", 32'(output_1), 32'(16'h2000 + i - 3));
            check("t5_level", 32'(level), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, '0, 0);

        // 6: reset mid-stream with traffic; overflow is still sticky from scenario 2
        for (int i = 0; i < 7; i++) cycle(1, 0, BN'(16'h3000 + i), 0);
        check("t6_pre_level", 32'(level), 32'd7);
        check("t6_pre_ovf", 32'(overflow), 32'd1);
        cycle(1, 1, 16'h3333, 1);
        check("t6_level", 32'(level), 32'd0);
        check("t6_out", 32'(output_1), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);

        // Random traffic with changing write/read bias and rare resets
        for (int blk = 0; blk < 8; blk++) begin
            int pw;
            int pr;
            pw = (blk % 2 == 0) ? 80 : 30;
            pr = (blk % 4 < 2) ? 40 : 85;
            for (int i = 0; i < 250; i++) begin
                cycle($urandom_range(99) < pw, $urandom_range(99) < pr,
                      BN'($urandom), $urandom_range(299) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
